// File: rtl/intersection_scheduler_pkg.sv
// Shared constants for the intersection phase scheduler.
// Covers phase codes, lamp colour encodings and requester bit positions.
package intersection_scheduler_pkg;

    localparam logic [2:0] PH_ALLRED = 3'd0;
    localparam logic [2:0] PH_GREEN  = 3'd1;
    localparam logic [2:0] PH_YELLOW = 3'd2;
    localparam logic [2:0] PH_WALK   = 3'd3;

    // Lamp encoding is {R,G,B}; yellow is red+green.
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;

    localparam int REQ_ROAD1 = 0;
    localparam int REQ_ROAD2 = 1;
    localparam int REQ_PED   = 2;

    // Round-robin pointer after a grant: the requester after the winner.
    function automatic logic [1:0] ptr_after(input logic [2:0] onehot);
        logic [1:0] ptr;
        ptr = 2'd0;
        if (onehot[REQ_ROAD1]) ptr = 2'd1;
        else if (onehot[REQ_ROAD2]) ptr = 2'd2;
        return ptr;
    endfunction

endpackage

// File: rtl/intersection_scheduler_rr_arbiter.sv
// Three-way combinational round-robin picker.
// Scans pending from the pointer position upward, wrapping 2 -> 0.
module rr_arbiter
    import intersection_scheduler_pkg::*;
(
    input  logic [2:0] pending_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] grant_o,
    output logic       valid_o
);

    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        grant_o = 3'b000;
        case (ptr_i)
            2'd1: begin
                if (pending_i[REQ_ROAD2])      grant_o[REQ_ROAD2] = 1'b1;
                else if (pending_i[REQ_PED])   grant_o[REQ_PED]   = 1'b1;
                else if (pending_i[REQ_ROAD1]) grant_o[REQ_ROAD1] = 1'b1;
            end
            2'd2: begin
                if (pending_i[REQ_PED])        grant_o[REQ_PED]   = 1'b1;
                else if (pending_i[REQ_ROAD1]) grant_o[REQ_ROAD1] = 1'b1;
                else if (pending_i[REQ_ROAD2]) grant_o[REQ_ROAD2] = 1'b1;
            end
            default: begin
                if (pending_i[REQ_ROAD1])      grant_o[REQ_ROAD1] = 1'b1;
                else if (pending_i[REQ_ROAD2]) grant_o[REQ_ROAD2] = 1'b1;
                else if (pending_i[REQ_PED])   grant_o[REQ_PED]   = 1'b1;
            end
        endcase
    end

    assign valid_o = |pending_i;

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-driven phase scheduler for a two-road intersection with a pedestrian crossing.
// Latches requests, grants round-robin and sequences GREEN/YELLOW/ALLRED/WALK on second ticks.
module intersection_scheduler
    import intersection_scheduler_pkg::*;
#(
    parameter int PHASE_W = 3,
    parameter int CNT_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               tick_i,
    input  logic [2:0]         req_i,
    input  logic [CNT_W-1:0]   green_len_i,
    input  logic [CNT_W-1:0]   yellow_len_i,
    input  logic [CNT_W-1:0]   allred_len_i,
    input  logic [CNT_W-1:0]   walk_len_i,
    output logic [2:0]         light1_o,
    output logic [2:0]         light2_o,
    output logic               walk_o,
    output logic [2:0]         grant_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic [CNT_W-1:0]   sec_o
);

    logic [PHASE_W-1:0] r_phase, w_phase_nxt;
    logic [CNT_W-1:0]   r_sec, w_sec_nxt;
    logic [2:0]         r_pending, w_pending_nxt;
    logic [2:0]         r_grant, w_grant_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt;
    logic [2:0]         w_served;
    logic [2:0]         w_arb_grant;
    logic               w_arb_valid;
    logic               w_expire;

    function automatic logic [CNT_W-1:0] len_or_one(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    rr_arbiter u_arb (
        .pending_i (r_pending),
        .ptr_i     (r_ptr),
        .grant_o   (w_arb_grant),
        .valid_o   (w_arb_valid)
    );

    // Idle ALLRED sits at zero and re-arbitrates on every tick.
    assign w_expire = tick_i &&
                      ((r_sec == CNT_W'(1)) || (r_phase == PH_ALLRED && r_sec == '0));

    always_comb begin
        w_phase_nxt = r_phase;
        w_sec_nxt   = r_sec;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_served    = 3'b000;
        if (w_expire) begin
            case (r_phase)
                PH_GREEN: begin
                    w_phase_nxt = PH_YELLOW;
                    w_sec_nxt   = len_or_one(yellow_len_i);
                end
                PH_YELLOW, PH_WALK: begin
                    w_phase_nxt = PH_ALLRED;
                    w_sec_nxt   = len_or_one(allred_len_i);
                    w_grant_nxt = 3'b000;
                end
                PH_ALLRED: begin
                    if (w_arb_valid) begin
                        w_grant_nxt = w_arb_grant;
                        w_ptr_nxt   = ptr_after(w_arb_grant);
                        w_served    = w_arb_grant;
                        if (w_arb_grant[REQ_PED]) begin
                            w_phase_nxt = PH_WALK;
                            w_sec_nxt   = len_or_one(walk_len_i);
                        end else begin
                            w_phase_nxt = PH_GREEN;
                            w_sec_nxt   = len_or_one(green_len_i);
                        end
                    end else begin
                        w_sec_nxt = '0;
                    end
                end
                default: begin
                    w_phase_nxt = PH_ALLRED;
                    w_sec_nxt   = '0;
                    w_grant_nxt = 3'b000;
                end
            endcase
        end else if (tick_i && r_sec != '0) begin
            w_sec_nxt = r_sec - 1'b1;
        end
    end

    // A request arriving on the entry edge is absorbed by the grant it already won.
    assign w_pending_nxt = (r_pending | req_i) & ~w_served;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_phase   <= PH_ALLRED;
            r_sec     <= '0;
            r_pending <= 3'b000;
            r_grant   <= 3'b000;
            r_ptr     <= 2'd0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            r_phase   <= w_phase_nxt;
            r_sec     <= w_sec_nxt;
            r_pending <= w_pending_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    always_comb begin
        light1_o = RED;
        light2_o = RED;
        walk_o   = 1'b0;
        case (r_phase)
            PH_GREEN: begin
                if (r_grant[REQ_ROAD1]) light1_o = GREEN;
                if (r_grant[REQ_ROAD2]) light2_o = GREEN;
            end
            PH_YELLOW: begin
                if (r_grant[REQ_ROAD1]) light1_o = YELLOW;
                if (r_grant[REQ_ROAD2]) light2_o = YELLOW;
            end
            PH_WALK: walk_o = 1'b1;
            default: ;
        endcase
    end

    assign grant_o = r_grant;
    assign phase_o = r_phase;
    assign sec_o   = r_sec;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: stimulus queues expected state per tick,
// a monitor compares after every tick edge and at explicit snapshot points.
module tb_intersection_scheduler;

    localparam logic [2:0] PA = 3'd0, PG = 3'd1, PY = 3'd2, PW = 3'd3;
    localparam logic [2:0] CR = 3'b100, CG = 3'b010, CY = 3'b110;
    localparam logic [2:0] G0 = 3'b000, G1 = 3'b001, G2 = 3'b010, GP = 3'b100;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       tick_i;
    logic [2:0] req_i;
    logic [3:0] green_len_i, yellow_len_i, allred_len_i, walk_len_i;
    logic [2:0] light1_o, light2_o, grant_o, phase_o;
    logic       walk_o;
    logic [3:0] sec_o;

    typedef struct {
        logic [2:0] ph;
        logic [3:0] sec;
        logic [2:0] l1;
        logic [2:0] l2;
        logic       wk;
        logic [2:0] gr;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         snap_cnt = 0;
    int         snap_done = 0;
    logic       tick_d = 1'b0;
    logic [2:0] req_hold = 3'b000;

    intersection_scheduler #(.PHASE_W(3), .CNT_W(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .tick_i       (tick_i),
        .req_i        (req_i),
        .green_len_i  (green_len_i),
        .yellow_len_i (yellow_len_i),
        .allred_len_i (allred_len_i),
        .walk_len_i   (walk_len_i),
        .light1_o     (light1_o),
        .light2_o     (light2_o),
        .walk_o       (walk_o),
        .grant_o      (grant_o),
        .phase_o      (phase_o),
        .sec_o        (sec_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick_d <= tick_i;

    task automatic push(input string n, input logic [2:0] ph, input logic [3:0] sec,
                        input logic [2:0] l1, input logic [2:0] l2, input logic wk,
                        input logic [2:0] gr);
        exp_t e;
        e.ph = ph; e.sec = sec; e.l1 = l1; e.l2 = l2; e.wk = wk; e.gr = gr; e.name = n;
        exp_q.push_back(e);
    endtask

    // One tick pulse; r is OR-ed onto the held requests during the tick cycle only.
    task automatic step(input string n, input logic [2:0] r, input logic [2:0] ph,
                        input logic [3:0] sec, input logic [2:0] l1, input logic [2:0] l2,
                        input logic wk, input logic [2:0] gr);
        push(n, ph, sec, l1, l2, wk, gr);
        @(negedge clk);
        tick_i = 1'b1;
        req_i  = req_hold | r;
        @(negedge clk);
        tick_i = 1'b0;
        req_i  = req_hold;
    endtask

    task automatic snap(input string n, input logic [2:0] ph, input logic [3:0] sec,
                        input logic [2:0] l1, input logic [2:0] l2, input logic wk,
                        input logic [2:0] gr);
        push(n, ph, sec, l1, l2, wk, gr);
        snap_cnt++;
    endtask

    task automatic pulse_req(input logic [2:0] r);
        @(negedge clk);
        req_i = req_hold | r;
        @(negedge clk);
        req_i = req_hold;
    endtask

    task automatic check();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL underflow: DUT output event with no expected entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if ({phase_o, sec_o, light1_o, light2_o, walk_o, grant_o} !==
                {e.ph, e.sec, e.l1, e.l2, e.wk, e.gr}) begin
                errors++;
                $display("FAIL %s @%0t: got phase=%0d sec=%0d l1=%b l2=%b walk=%b grant=%b, want phase=%0d sec=%0d l1=%b l2=%b walk=%b grant=%b",
                         e.name, $time, phase_o, sec_o, light1_o, light2_o, walk_o, grant_o,
                         e.ph, e.sec, e.l1, e.l2, e.wk, e.gr);
            end
        end
    endtask

    // Monitor: compare after each tick edge, or when a snapshot has been requested.
    initial begin
        forever begin
            @(negedge clk);
            if (tick_d) check();
            else if (snap_cnt != snap_done) begin
                snap_done++;
                check();
            end
        end
    end

    initial begin
        rst_ni = 1'b0; tick_i = 1'b0; req_i = 3'b000;
        green_len_i = 4'd5; yellow_len_i = 4'd1; allred_len_i = 4'd1; walk_len_i = 4'd1;

        repeat (2) @(negedge clk);
        #1 snap("reset", PA, 4'd0, CR, CR, 1'b0, G0);
        @(negedge clk);
        #1 rst_ni = 1'b1;

        // Idle: no requests, stays in ALLRED at zero.
        for (int k = 0; k < 10; k++) step("idle", 3'b000, PA, 4'd0, CR, CR, 1'b0, G0);

        // All requests held: round-robin road1, road2, ped, road1.
        green_len_i = 4'd3; yellow_len_i = 4'd1; allred_len_i = 4'd2; walk_len_i = 4'd4;
        req_hold = 3'b111; req_i = 3'b111;
        step("rr_g1_3", 3'b000, PG, 4'd3, CG, CR, 1'b0, G1);
        step("rr_g1_2", 3'b000, PG, 4'd2, CG, CR, 1'b0, G1);
        step("rr_g1_1", 3'b000, PG, 4'd1, CG, CR, 1'b0, G1);
        step("rr_y1",   3'b000, PY, 4'd1, CY, CR, 1'b0, G1);
        step("rr_ar_2", 3'b000, PA, 4'd2, CR, CR, 1'b0, G0);
        step("rr_ar_1", 3'b000, PA, 4'd1, CR, CR, 1'b0, G0);
        step("rr_g2_3", 3'b000, PG, 4'd3, CR, CG, 1'b0, G2);
        step("rr_g2_2", 3'b000, PG, 4'd2, CR, CG, 1'b0, G2);
        step("rr_g2_1", 3'b000, PG, 4'd1, CR, CG, 1'b0, G2);
        step("rr_y2",   3'b000, PY, 4'd1, CR, CY, 1'b0, G2);
        step("rr_ar_2", 3'b000, PA, 4'd2, CR, CR, 1'b0, G0);
        step("rr_ar_1", 3'b000, PA, 4'd1, CR, CR, 1'b0, G0);
        for (int k = 4; k >= 1; k--) step("rr_walk", 3'b000, PW, 4'(k), CR, CR, 1'b1, GP);
        step("rr_ar_2", 3'b000, PA, 4'd2, CR, CR, 1'b0, G0);
        step("rr_ar_1", 3'b000, PA, 4'd1, CR, CR, 1'b0, G0);
        step("rr_g1b_3", 3'b000, PG, 4'd3, CG, CR, 1'b0, G1);
        step("rr_g1b_2", 3'b000, PG, 4'd2, CG, CR, 1'b0, G1);
        step("rr_g1b_1", 3'b000, PG, 4'd1, CG, CR, 1'b0, G1);
        step("rr_y1b",   3'b000, PY, 4'd1, CY, CR, 1'b0, G1);

        // Asynchronous reset in the middle of YELLOW.
        req_hold = 3'b000; req_i = 3'b000;
        @(posedge clk);
        #1 rst_ni = 1'b0;
        snap("reset_in_yellow", PA, 4'd0, CR, CR, 1'b0, G0);
        @(negedge clk);
        #1 rst_ni = 1'b1;
        step("post_reset_idle", 3'b000, PA, 4'd0, CR, CR, 1'b0, G0);
        step("post_reset_idle", 3'b000, PA, 4'd0, CR, CR, 1'b0, G0);

        // Single road-1 pulse, lengths 5/1/1.
        green_len_i = 4'd5; yellow_len_i = 4'd1; allred_len_i = 4'd1;
        pulse_req(3'b001);
        for (int k = 5; k >= 1; k--) step("r1_green", 3'b000, PG, 4'(k), CG, CR, 1'b0, G1);
        step("r1_yellow", 3'b000, PY, 4'd1, CY, CR, 1'b0, G1);
        step("r1_allred", 3'b000, PA, 4'd1, CR, CR, 1'b0, G0);
        step("r1_idle",   3'b000, PA, 4'd0, CR, CR, 1'b0, G0);
        step("r1_idle",   3'b000, PA, 4'd0, CR, CR, 1'b0, G0);

        // Green length changed mid-phase; yellow length 0 runs one tick.
        yellow_len_i = 4'd0;
        pulse_req(3'b001);
        step("gchg_g5", 3'b000, PG, 4'd5, CG, CR, 1'b0, G1);
        green_len_i = 4'd9;
        for (int k = 4; k >= 1; k--) step("gchg_g5", 3'b000, PG, 4'(k), CG, CR, 1'b0, G1);
        step("y0_yellow", 3'b000, PY, 4'd1, CY, CR, 1'b0, G1);
        step("gchg_ar",   3'b000, PA, 4'd1, CR, CR, 1'b0, G0);
        step("gchg_idle", 3'b000, PA, 4'd0, CR, CR, 1'b0, G0);
        pulse_req(3'b001);
        for (int k = 9; k >= 1; k--) step("gchg_g9", 3'b000, PG, 4'(k), CG, CR, 1'b0, G1);
        step("y0_yellow2", 3'b000, PY, 4'd1, CY, CR, 1'b0, G1);
        step("gchg_ar2",   3'b000, PA, 4'd1, CR, CR, 1'b0, G0);
        step("gchg_idle2", 3'b000, PA, 4'd0, CR, CR, 1'b0, G0);

        // Road-2 request re-asserted on its own GREEN entry edge is absorbed.
        green_len_i = 4'd2; yellow_len_i = 4'd1; allred_len_i = 4'd1;
        pulse_req(3'b010);
        step("same_g2_2", 3'b010, PG, 4'd2, CR, CG, 1'b0, G2);
        step("same_g2_1", 3'b000, PG, 4'd1, CR, CG, 1'b0, G2);
        step("same_y2",   3'b000, PY, 4'd1, CR, CY, 1'b0, G2);
        step("same_ar",   3'b000, PA, 4'd1, CR, CR, 1'b0, G0);
        step("same_noextra", 3'b000, PA, 4'd0, CR, CR, 1'b0, G0);
        step("same_noextra", 3'b000, PA, 4'd0, CR, CR, 1'b0, G0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Phase scheduler for the two-road traffic-light intersection with a pedestrian crossing. Latches service requests from two road sensors and a pedestrian button, grants the intersection to one requester at a time by round-robin, and sequences green, yellow, all-red and walk phases using a one-pulse-per-second tick from the clock divider. It sits between the debounced inputs and the light outputs and replaces fixed-cycle sequencing with demand-driven sequencing.

## Interface
- PHASE_W, 3: phase/state code width
- CNT_W, 4: width of phase lengths and seconds counter
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- tick_i  in  1  one-cycle pulse per second, synchronous to clk_i
- req_i  in  3  level requests: [0] road 1 car, [1] road 2 car, [2] pedestrian (debounced)
- green_len_i  in  CNT_W  green length, seconds
- yellow_len_i  in  CNT_W  yellow length, seconds
- allred_len_i  in  CNT_W  all-red clearance length, seconds
- walk_len_i  in  CNT_W  pedestrian walk length, seconds
- light1_o  out  3  road 1 colour {R,G,B}: RED 100, GREEN 010, YELLOW 110
- light2_o  out  3  road 2 colour, same encoding
- walk_o  out  1  pedestrian walk lamp
- grant_o  out  3  one-hot current grantee, 0 when none
- phase_o  out  PHASE_W  current phase code
- sec_o  out  CNT_W  seconds remaining in phase

## Operation
- Phases: ALLRED, GREEN, YELLOW, WALK. Reset: ALLRED, sec_o=0, pending=000, rr pointer=0, grant_o=000, both lights RED, walk_o=0.
- Pending: pending[i] sets on any cycle req_i[i]=1; clears on the cycle its grant phase (GREEN or WALK) is entered. Set and clear in the same cycle: clear wins; request counts as served.
- Counter: loads the phase length on phase entry; otherwise decrements by 1 on tick_i when nonzero. A length of 0 loads as 1. Lengths are sampled only at entry; mid-phase changes take effect at the next entry of that phase.
- Phase exit occurs on the tick_i cycle where sec_o==1, or sec_o==0 in ALLRED.
  - GREEN -> YELLOW (same grantee); YELLOW -> ALLRED; WALK -> ALLRED (no yellow).
  - ALLRED at expiry: arbitrate. Scan pending starting at pointer, wrapping 0->1->2->0; the first set bit wins. Road grant -> GREEN; pedestrian grant -> WALK. Pointer becomes (winner+1) mod 3.
  - ALLRED with no pending: stay in ALLRED with sec_o=0 and re-arbitrate on every tick.
- Outputs are Moore, decoded from registered state.
  - GREEN/YELLOW: the granted road shows GREEN/YELLOW; the other road is RED.
  - WALK: both roads RED, walk_o=1.
  - ALLRED: both roads RED, grant_o=000.
- Road grant with pedestrian pending: the road phase still completes before WALK is entered.

## Timing
- req_i to pending: one clk_i edge.
- All state, counter and output changes occur only on clk_i edges with tick_i=1. Exceptions: pending set and reset.
- Arbitration result is visible on the same edge as the ALLRED expiry tick; sec_o shows the loaded length immediately.
- Phase durations in ticks: GREEN=max(green_len,1), YELLOW=max(yellow_len,1), WALK=max(walk_len,1), ALLRED=max(allred_len,1) when entered from service.
- Reset assertion mid-phase forces the reset values asynchronously. Deassertion is synchronous to clk_i; the first arbitration happens on the first tick_i after reset is released.

## Structure
- Shared package: phase codes, colour constants RED/GREEN/YELLOW, requester indices REQ_ROAD1/REQ_ROAD2/REQ_PED.
- Sub-module rr_arbiter: 3-way combinational round-robin picker. Takes pending and pointer; returns one-hot winner and a valid flag. The scheduler holds the pointer register.

## Test plan
- After reset, no req, 10 ticks -> phase ALLRED, sec_o=0, both lights 100, grant_o=000 throughout.
- req_i=001 pulse, lengths 5/1/1 -> GREEN on road 1 for 5 ticks, YELLOW 1 tick, ALLRED 1 tick, then idle ALLRED. light1_o sequence 010,110,100.
- req_i=111 held, lengths 3/1/2, walk 4 -> grants in order road1, road2, ped, road1. WALK lasts 4 ticks with walk_o=1 and both lights 100.
- green_len_i changed 5->9 mid-GREEN -> current green still lasts 5 ticks; next green lasts 9.
- yellow_len_i=0 -> YELLOW lasts exactly 1 tick.
- req_i[1] asserted on the same cycle road 2 enters GREEN -> pending[1] ends cleared; no extra road-2 grant follows.
- rst_ni low during YELLOW -> outputs return to reset values immediately. After release, pending=000 and the phase is ALLRED.
